// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and the pixel pipeline (slave).
// The frame_cnt signal and the FCW parameter exist only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CW  = 10
`ifdef VGA_FRAME_CNT_EN
  , parameter int FCW = 8
`endif
);
  logic          pix_ce;
  logic          hsync;
  logic          vsync;
  logic          sync_b;
  logic          blank_b;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt;

  modport master (input pix_ce, output hsync, vsync, sync_b, blank_b, x, y,
                  line_start, frame_start, frame_cnt);
  modport slave  (output pix_ce, input hsync, vsync, sync_b, blank_b, x, y,
                  line_start, frame_start, frame_cnt);
`else
  modport master (input pix_ce, output hsync, vsync, sync_b, blank_b, x, y,
                  line_start, frame_start);
  modport slave  (output pix_ce, input hsync, vsync, sync_b, blank_b, x, y,
                  line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock enable and DELAY output stages.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int CW      = 10,
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYN    = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 11,
  parameter int VSYN    = 2,
  parameter int VBP     = 32,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int DELAY   = 0,
  parameter int FCW     = 8
) (
  input  logic           vgaclk,
  input  logic           reset,
  vga_timing_gen_if.master vga
);

  localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
  localparam int VMAX = VACTIVE + VFP + VSYN + VBP;

  // Decode thresholds carry one extra bit so HMAX == 2**CW still compares correctly.
  localparam logic [CW:0]   HACT_C     = (CW+1)'(HACTIVE);
  localparam logic [CW:0]   HS_START_C = (CW+1)'(HACTIVE + HFP);
  localparam logic [CW:0]   HS_END_C   = (CW+1)'(HACTIVE + HFP + HSYN);
  localparam logic [CW:0]   VACT_C     = (CW+1)'(VACTIVE);
  localparam logic [CW:0]   VS_START_C = (CW+1)'(VACTIVE + VFP);
  localparam logic [CW:0]   VS_END_C   = (CW+1)'(VACTIVE + VFP + VSYN);
  localparam logic [CW-1:0] H_LAST_C   = CW'(HMAX - 1);
  localparam logic [CW-1:0] V_LAST_C   = CW'(VMAX - 1);

  if (HMAX > (2 ** CW)) begin : g_hmax_chk
    $error("vga_timing_gen: HMAX does not fit in CW bits");
  end
  if (VMAX > (2 ** CW)) begin : g_vmax_chk
    $error("vga_timing_gen: VMAX does not fit in CW bits");
  end
  if ((DELAY < 0) || (DELAY > 3)) begin : g_delay_chk
    $error("vga_timing_gen: DELAY must be 0..3");
  end
  if (FCW < 1) begin : g_fcw_chk
    $error("vga_timing_gen: FCW must be at least 1");
  end

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          sync_b;
    logic          blank_b;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [FCW-1:0] frame_cnt;
`endif
  } stage_t;

  function automatic stage_t rst_stage();
    stage_t s;
    s.hsync       = ~HS_POL;
    s.vsync       = ~VS_POL;
    s.sync_b      = 1'b1;
    s.blank_b     = 1'b0;
    s.x           = {CW{1'b0}};
    s.y           = {CW{1'b0}};
    s.line_start  = 1'b0;
    s.frame_start = 1'b0;
`ifdef VGA_FRAME_CNT_EN
    s.frame_cnt   = {FCW{1'b0}};
`endif
    return s;
  endfunction

  logic [CW-1:0] h_r;
  logic [CW-1:0] v_r;
  logic [CW-1:0] h_nxt_s;
  logic [CW-1:0] v_nxt_s;
  logic          hs_act_s;
  logic          vs_act_s;
  stage_t        dec_s;
  stage_t        stage_r [0:DELAY];
`ifdef VGA_FRAME_CNT_EN
  logic [FCW-1:0] fcount_r;
`endif

  // Raster position next-state: wrap h at end of line, step v on each wrap.
  always_comb begin
    h_nxt_s = h_r + CW'(1);
    v_nxt_s = v_r;
    if (h_r == H_LAST_C) begin
      h_nxt_s = {CW{1'b0}};
      if (v_r == V_LAST_C) begin
        v_nxt_s = {CW{1'b0}};
      end else begin
        v_nxt_s = v_r + CW'(1);
      end
    end else begin
      h_nxt_s = h_r + CW'(1);
    end
  end

  // Raster position counters, advancing on enabled pixel edges.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      h_r <= {CW{1'b0}};
      v_r <= {CW{1'b0}};
    end else if (vga.pix_ce) begin
      h_r <= h_nxt_s;
      v_r <= v_nxt_s;
    end
  end

  // Decode of the current position into the first pipeline stage contents.
  always_comb begin
    hs_act_s          = ({1'b0, h_r} >= HS_START_C) && ({1'b0, h_r} < HS_END_C);
    vs_act_s          = ({1'b0, v_r} >= VS_START_C) && ({1'b0, v_r} < VS_END_C);
    dec_s             = rst_stage();
    dec_s.hsync       = hs_act_s ? HS_POL : ~HS_POL;
    dec_s.vsync       = vs_act_s ? VS_POL : ~VS_POL;
    dec_s.sync_b      = ~(hs_act_s | vs_act_s);
    dec_s.blank_b     = ({1'b0, h_r} < HACT_C) && ({1'b0, v_r} < VACT_C);
    dec_s.x           = h_r;
    dec_s.y           = v_r;
    dec_s.line_start  = (h_r == {CW{1'b0}});
    dec_s.frame_start = (h_r == {CW{1'b0}}) && (v_r == {CW{1'b0}});
`ifdef VGA_FRAME_CNT_EN
    // Count only changes alongside frame_start; otherwise the stage keeps its value.
    if (dec_s.frame_start) begin
      dec_s.frame_cnt = fcount_r;
    end else begin
      dec_s.frame_cnt = stage_r[0].frame_cnt;
    end
`endif
  end

`ifdef VGA_FRAME_CNT_EN
  // Frames started so far; the first frame_start after reset shows zero.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      fcount_r <= {FCW{1'b0}};
    end else if (vga.pix_ce && dec_s.frame_start) begin
      fcount_r <= fcount_r + FCW'(1);
    end
  end
`endif

  // Decode stage followed by DELAY alignment stages, all moving together on pix_ce.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= DELAY; i++) begin
        stage_r[i] <= rst_stage();
      end
    end else if (vga.pix_ce) begin
      stage_r[0] <= dec_s;
      for (int i = 1; i <= DELAY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign vga.hsync       = stage_r[DELAY].hsync;
  assign vga.vsync       = stage_r[DELAY].vsync;
  assign vga.sync_b      = stage_r[DELAY].sync_b;
  assign vga.blank_b     = stage_r[DELAY].blank_b;
  assign vga.x           = stage_r[DELAY].x;
  assign vga.y           = stage_r[DELAY].y;
  assign vga.line_start  = stage_r[DELAY].line_start;
  assign vga.frame_start = stage_r[DELAY].frame_start;
`ifdef VGA_FRAME_CNT_EN
  assign vga.frame_cnt   = stage_r[DELAY].frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a small inverted-polarity
// DELAY=2 instance, both compared every cycle against a reference raster model.
module tb_vga_timing_gen;

  logic vgaclk = 1'b0;
  logic reset;

  always #5 vgaclk = ~vgaclk;

  vga_timing_gen_if #(
    .CW(10)
`ifdef VGA_FRAME_CNT_EN
    , .FCW(8)
`endif
  ) if0 ();

  vga_timing_gen_if #(
    .CW(10)
`ifdef VGA_FRAME_CNT_EN
    , .FCW(4)
`endif
  ) if1 ();

  vga_timing_gen #(.CW(10)) u_def (
    .vgaclk (vgaclk),
    .reset  (reset),
    .vga    (if0)
  );

  vga_timing_gen #(
    .CW(10), .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
    .VACTIVE(6), .VFP(1), .VSYN(2), .VBP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DELAY(2), .FCW(4)
  ) u_sml (
    .vgaclk (vgaclk),
    .reset  (reset),
    .vga    (if1)
  );

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       sync_b;
    logic       blank_b;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
    logic [7:0] fc;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mh[2], mv[2], fshow[2], fnext[2];
  obs_t q0[$];
  obs_t q1[$];
  obs_t e0, e1;

  function automatic int hmax(input int d);
    return (d == 0) ? 800 : 15;
  endfunction

  function automatic int vmax(input int d);
    return (d == 0) ? 525 : 10;
  endfunction

  function automatic obs_t rst_obs(input int d);
    obs_t o;
    o = '0;
    o.hsync  = (d == 0);
    o.vsync  = (d == 0);
    o.sync_b = 1'b1;
    return o;
  endfunction

  function automatic obs_t decode(input int d, input int h, input int v, input int fc);
    int ha, hf, hw, va, vf, vw;
    bit hp, vp, hsa, vsa;
    obs_t o;
    if (d == 0) begin
      ha = 640; hf = 16; hw = 96; va = 480; vf = 11; vw = 2; hp = 1'b0; vp = 1'b0;
    end else begin
      ha = 8; hf = 2; hw = 3; va = 6; vf = 1; vw = 2; hp = 1'b1; vp = 1'b1;
    end
    hsa = (h >= ha + hf) && (h < ha + hf + hw);
    vsa = (v >= va + vf) && (v < va + vf + vw);
    o.hsync       = hsa ? hp : !hp;
    o.vsync       = vsa ? vp : !vp;
    o.sync_b      = !(hsa || vsa);
    o.blank_b     = (h < ha) && (v < va);
    o.x           = 10'(h);
    o.y           = 10'(v);
    o.line_start  = (h == 0);
    o.frame_start = (h == 0) && (v == 0);
`ifdef VGA_FRAME_CNT_EN
    o.fc          = 8'(fc);
`else
    o.fc          = 8'd0;
`endif
    return o;
  endfunction

  function automatic obs_t get_obs0();
    obs_t o;
    o.hsync = if0.hsync; o.vsync = if0.vsync; o.sync_b = if0.sync_b; o.blank_b = if0.blank_b;
    o.x = if0.x; o.y = if0.y; o.line_start = if0.line_start; o.frame_start = if0.frame_start;
`ifdef VGA_FRAME_CNT_EN
    o.fc = if0.frame_cnt;
`else
    o.fc = 8'd0;
`endif
    return o;
  endfunction

  function automatic obs_t get_obs1();
    obs_t o;
    o.hsync = if1.hsync; o.vsync = if1.vsync; o.sync_b = if1.sync_b; o.blank_b = if1.blank_b;
    o.x = if1.x; o.y = if1.y; o.line_start = if1.line_start; o.frame_start = if1.frame_start;
`ifdef VGA_FRAME_CNT_EN
    o.fc = {4'h0, if1.frame_cnt};
`else
    o.fc = 8'd0;
`endif
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mh[d] = 0; mv[d] = 0; fshow[d] = 0; fnext[d] = 0;
    end
    q0.delete();
    q1.delete();
    e0 = rst_obs(0);
    e1 = rst_obs(1);
    q1.push_back(rst_obs(1));
    q1.push_back(rst_obs(1));
  endtask

  // Push the decode of the model position, pop what the outputs must show now.
  task automatic model_edge(input int d);
    obs_t o;
    if (mh[d] == 0 && mv[d] == 0) begin
      fshow[d] = fnext[d];
      fnext[d] = (fnext[d] + 1) % ((d == 0) ? 256 : 16);
    end
    o = decode(d, mh[d], mv[d], fshow[d]);
    if (d == 0) begin
      q0.push_back(o);
      e0 = q0.pop_front();
    end else begin
      q1.push_back(o);
      e1 = q1.pop_front();
    end
    if (mh[d] == hmax(d) - 1) begin
      mh[d] = 0;
      mv[d] = (mv[d] == vmax(d) - 1) ? 0 : mv[d] + 1;
    end else begin
      mh[d] = mh[d] + 1;
    end
  endtask

  task automatic advance(input bit ce0, input bit ce1);
    @(negedge vgaclk);
    if0.pix_ce = ce0;
    if1.pix_ce = ce1;
    @(posedge vgaclk);
    cyc++;
    if (ce0) model_edge(0);
    if (ce1) model_edge(1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.pix_ce = 1'b0;
    if1.pix_ce = 1'b0;
    repeat (3) @(negedge vgaclk);
    checks++;
    if (get_obs0() !== rst_obs(0)) begin
      errors++; $display("FAIL reset_def got %h want %h", get_obs0(), rst_obs(0));
    end
    checks++;
    if (get_obs1() !== rst_obs(1)) begin
      errors++; $display("FAIL reset_sml got %h want %h", get_obs1(), rst_obs(1));
    end
    reset = 1'b0;
    model_reset();
    advance(1'b0, 1'b0);
    checks++;
    if (get_obs0() !== e0 || get_obs1() !== e1) begin
      errors++; $display("FAIL reset_hold got %h/%h want %h/%h", get_obs0(), get_obs1(), e0, e1);
    end
  endtask

  task automatic test_first_edge();
    for (int k = 1; k <= 3; k++) begin
      advance(1'b1, 1'b1);
      checks++;
      if (get_obs0() !== e0) begin
        errors++; $display("FAIL first_def edge %0d got %h want %h", k, get_obs0(), e0);
      end
      checks++;
      if (get_obs1() !== e1) begin
        errors++; $display("FAIL first_sml edge %0d got %h want %h", k, get_obs1(), e1);
      end
      checks++;
      if (if1.frame_start !== (k == 3)) begin
        errors++; $display("FAIL delay_fs edge %0d got %b want %b", k, if1.frame_start, (k == 3));
      end
      if (k == 1) begin
        checks++;
        if ({if0.blank_b, if0.line_start, if0.frame_start} !== 3'b111) begin
          errors++;
          $display("FAIL first_strobes got %b want 111",
                   {if0.blank_b, if0.line_start, if0.frame_start});
        end
      end
    end
  endtask

  task automatic test_raster();
    int last_ls = -1;
    for (int i = 0; i < 1700; i++) begin
      advance(1'b1, 1'b1);
      checks++;
      if (get_obs0() !== e0) begin
        errors++; $display("FAIL raster_def cyc %0d got %h want %h", cyc, get_obs0(), e0);
      end
      checks++;
      if (get_obs1() !== e1) begin
        errors++; $display("FAIL raster_sml cyc %0d got %h want %h", cyc, get_obs1(), e1);
      end
      if (if0.line_start === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != 800) begin
            errors++; $display("FAIL line_period got %0d want 800", cyc - last_ls);
          end
        end
        last_ls = cyc;
      end
    end
  endtask

  task automatic test_pix_ce();
    int   last_ls = -1;
    logic prev_ls;
    prev_ls = if0.line_start;
    for (int i = 0; i < 4000; i++) begin
      advance((i % 2) == 0, (i % 2) == 0);
      checks++;
      if (get_obs0() !== e0) begin
        errors++; $display("FAIL ce_def cyc %0d got %h want %h", cyc, get_obs0(), e0);
      end
      checks++;
      if (get_obs1() !== e1) begin
        errors++; $display("FAIL ce_sml cyc %0d got %h want %h", cyc, get_obs1(), e1);
      end
      if (if0.line_start === 1'b1 && prev_ls === 1'b0) begin
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != 1600) begin
            errors++; $display("FAIL ce_line_period got %0d want 1600", cyc - last_ls);
          end
        end
        last_ls = cyc;
      end
      prev_ls = if0.line_start;
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    while (e0.x != 10'd300 && n < 1000) begin
      advance(1'b1, 1'b1);
      n++;
    end
    checks++;
    if (get_obs0() !== e0) begin
      errors++; $display("FAIL pre_reset got %h want %h (steps %0d)", get_obs0(), e0, n);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (get_obs0() !== rst_obs(0)) begin
      errors++; $display("FAIL async_def got %h want %h", get_obs0(), rst_obs(0));
    end
    checks++;
    if (get_obs1() !== rst_obs(1)) begin
      errors++; $display("FAIL async_sml got %h want %h", get_obs1(), rst_obs(1));
    end
    @(negedge vgaclk);
    if0.pix_ce = 1'b0;
    if1.pix_ce = 1'b0;
    repeat (2) @(negedge vgaclk);
    reset = 1'b0;
    model_reset();
    advance(1'b1, 1'b1);
    checks++;
    if ({if0.frame_start, if0.x, if0.y} !== {1'b1, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL resume got fs=%b x=%0d y=%0d want fs=1 x=0 y=0",
               if0.frame_start, if0.x, if0.y);
    end
  endtask

  task automatic test_frames();
    int   k = 0;
    int   last_fs = -1;
    int   n = 0;
    logic prev_fs;
    prev_fs = if1.frame_start;
    while (k < 17 && n < 2700) begin
      advance(1'b1, 1'b1);
      n++;
      checks++;
      if (get_obs0() !== e0) begin
        errors++; $display("FAIL frames_def cyc %0d got %h want %h", cyc, get_obs0(), e0);
      end
      checks++;
      if (get_obs1() !== e1) begin
        errors++; $display("FAIL frames_sml cyc %0d got %h want %h", cyc, get_obs1(), e1);
      end
      if (if1.frame_start === 1'b1 && prev_fs === 1'b0) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != 150) begin
            errors++; $display("FAIL frame_period got %0d want 150", cyc - last_fs);
          end
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (if1.frame_cnt !== 4'(k % 16)) begin
          errors++; $display("FAIL frame_cnt frame %0d got %0d want %0d", k, if1.frame_cnt, k % 16);
        end
`endif
        last_fs = cyc;
        k++;
      end
      prev_fs = if1.frame_start;
    end
    checks++;
    if (k < 17) begin
      errors++; $display("FAIL frame_timeout got %0d frames want 17", k);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_raster();
    test_pix_ce();
    test_async_reset();
    test_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
